// File: rtl/seg7_scan_decoder_pkg.sv
// Shared 7-segment definitions: legal active-low patterns, blank code and the
// pattern-to-nibble decode used by both the encoder and the scan decoder.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    // Index of each entry is the hex nibble it displays (bit6=g ... bit0=a)
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
        7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
        7'b000_0000, 7'b001_0000, 7'b000_1000, 7'b000_0011,
        7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110
    };

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } seg7_dec_t;

    function automatic seg7_dec_t seg7_decode(input logic [6:0] seg_n);
        seg7_dec_t r;
        r.legal  = 1'b0;
        r.blank  = (seg_n == SEG_BLANK);
        r.nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            r.legal  = r.legal | (seg_n == SEG_TABLE[i]);
            r.nibble = (seg_n == SEG_TABLE[i]) ? 4'(i) : r.nibble;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Decoded-result stream: one beat per accepted non-blank pattern, valid/ready handshake.
interface seg7_scan_decoder_if #(
    parameter int IW = 3
);
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_digit;
    logic [3:0]    out_nibble;
    logic          out_err;

    modport master (output out_valid, output out_digit, output out_nibble, output out_err,
                    input  out_ready);
    modport slave  (input  out_valid, input  out_digit, input  out_nibble, input  out_err,
                    output out_ready);
endinterface

// File: rtl/seg7_scan_decoder_filter.sv
// Stability filter: a {segment, strobe} sample must repeat for STABLE_CYCLES edges with a
// one-hot strobe before it produces a single accept pulse; any change re-arms it.
module seg7_stability_filter #(
    parameter int NDIGITS       = 6,
    parameter int STABLE_CYCLES = 4,
    parameter int IW            = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [6:0]         seg_n_i,
    input  logic [NDIGITS-1:0] dig_sel_i,
    output logic               accept_o,
    output logic [IW-1:0]      idx_o
);
    import seg7_pkg::*;

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [6:0]         prev_seg_q;
    logic [NDIGITS-1:0] prev_sel_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic               onehot_s;
    logic               same_s;
    logic [IW-1:0]      idx_s;

    // Stability qualification, saturating count and strobe-to-index conversion
    always_comb begin
        onehot_s = (dig_sel_i != '0) && ((dig_sel_i & (dig_sel_i - NDIGITS'(1))) == '0);
        same_s   = (seg_n_i == prev_seg_q) && (dig_sel_i == prev_sel_q);
        cnt_d    = '0;
        if (same_s && onehot_s) begin
            cnt_d = (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
        idx_s = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            idx_s = dig_sel_i[i] ? IW'(i) : idx_s;
        end
    end

    // Fires only on the transition into saturation, so a long hold yields one pulse
    assign accept_o = same_s && onehot_s && (cnt_q == CW'(STABLE_CYCLES - 1));
    assign idx_o    = idx_s;

    // Sample history and stability counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_seg_q <= SEG_BLANK;
            prev_sel_q <= '0;
            cnt_q      <= '0;
        end else begin
            prev_seg_q <= seg_n_i;
            prev_sel_q <= dig_sel_i;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Captures a multiplexed active-low 7-segment bus, decodes stable patterns to nibbles and
// publishes them on a one-deep valid/ready stream plus a per-digit register file.
module seg7_scan_decoder #(
    parameter int NDIGITS       = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           seg_n,
    input  logic [NDIGITS-1:0]   dig_sel,
    seg7_scan_decoder_if.master  strm,
    output logic [4*NDIGITS-1:0] digit_vals,
    output logic [NDIGITS-1:0]   digit_errs,
    output logic [NDIGITS-1:0]   digit_blank,
    output logic                 overflow
);
    import seg7_pkg::*;

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    logic                 accept_s;
    logic [IW-1:0]        idx_s;
    seg7_dec_t            dec_s;
    logic                 pop_s;

    logic [4*NDIGITS-1:0] vals_q,  vals_d;
    logic [NDIGITS-1:0]   errs_q,  errs_d;
    logic [NDIGITS-1:0]   blank_q, blank_d;
    logic                 valid_q, valid_d;
    logic [IW-1:0]        digit_q, digit_d;
    logic [3:0]           nibble_q, nibble_d;
    logic                 err_q,   err_d;
    logic                 ovf_q,   ovf_d;

    seg7_stability_filter #(
        .NDIGITS       (NDIGITS),
        .STABLE_CYCLES (STABLE_CYCLES),
        .IW            (IW)
    ) u_filter (
        .clk       (clk),
        .reset_n   (reset_n),
        .seg_n_i   (seg_n),
        .dig_sel_i (dig_sel),
        .accept_o  (accept_s),
        .idx_o     (idx_s)
    );

    assign dec_s = seg7_decode(seg_n);

    // Register-file update and stream load; dig_sel is one-hot whenever accept_s is high
    always_comb begin
        pop_s    = valid_q & strm.out_ready;
        vals_d   = vals_q;
        errs_d   = errs_q;
        blank_d  = blank_q;
        valid_d  = valid_q & ~pop_s;
        digit_d  = digit_q;
        nibble_d = nibble_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        if (accept_s && dec_s.blank) begin
            blank_d = blank_q | dig_sel;
        end else if (accept_s) begin
            for (int i = 0; i < NDIGITS; i++) begin
                vals_d[4*i +: 4] = dig_sel[i] ? (dec_s.legal ? dec_s.nibble : 4'h0)
                                              : vals_q[4*i +: 4];
            end
            errs_d  = (errs_q & ~dig_sel) | (dig_sel & {NDIGITS{~dec_s.legal}});
            blank_d = blank_q & ~dig_sel;
            if (!valid_q || pop_s) begin
                valid_d  = 1'b1;
                digit_d  = idx_s;
                nibble_d = dec_s.legal ? dec_s.nibble : 4'h0;
                err_d    = ~dec_s.legal;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers; a reset drops any pending stream beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vals_q   <= '0;
            errs_q   <= '0;
            blank_q  <= '1;
            valid_q  <= 1'b0;
            digit_q  <= '0;
            nibble_q <= 4'h0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            vals_q   <= vals_d;
            errs_q   <= errs_d;
            blank_q  <= blank_d;
            valid_q  <= valid_d;
            digit_q  <= digit_d;
            nibble_q <= nibble_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    assign strm.out_valid  = valid_q;
    assign strm.out_digit  = digit_q;
    assign strm.out_nibble = nibble_q;
    assign strm.out_err    = err_q;
    assign digit_vals      = vals_q;
    assign digit_errs      = errs_q;
    assign digit_blank     = blank_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench: a run-length reference model predicts beats and register-file contents.
module tb_seg7_scan_decoder;

    localparam int ND = 6;
    localparam int SC = 4;
    localparam int IW = 3;

    localparam logic [6:0] REF [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [6:0]      seg_n = 7'h7F;
    logic [ND-1:0]   dig_sel = '0;
    logic [4*ND-1:0] digit_vals;
    logic [ND-1:0]   digit_errs;
    logic [ND-1:0]   digit_blank;
    logic            overflow;

    seg7_scan_decoder_if #(.IW(IW)) strm();

    seg7_scan_decoder #(.NDIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg_n       (seg_n),
        .dig_sel     (dig_sel),
        .strm        (strm),
        .digit_vals  (digit_vals),
        .digit_errs  (digit_errs),
        .digit_blank (digit_blank),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int digit;
        int nib;
        bit err;
    } beat_t;

    beat_t           sb[$];
    int              tests = 0;
    int              fails = 0;
    int              n_beats = 0;

    int              m_val [ND];
    bit              m_err [ND];
    bit              m_blank [ND];
    bit              m_ovf;
    bit              m_full;
    logic [6+ND:0]   m_last;
    int              m_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // -2 blank, -1 illegal, else the nibble shown
    function automatic int ref_decode(input logic [6:0] p);
        if (p == 7'h7F) return -2;
        for (int i = 0; i < 16; i++) if (REF[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_val[i] = 0; m_err[i] = 1'b0; m_blank[i] = 1'b1;
        end
        m_ovf  = 1'b0;
        m_full = 1'b0;
        m_last = {7'h7F, {ND{1'b0}}};
        m_run  = 1;
        sb.delete();
    endtask

    // Accept when the same sample has been seen on SC+1 consecutive edges with one strobe bit
    task automatic model_edge();
        logic [6+ND:0] cur;
        int d, code;
        cur = {seg_n, dig_sel};
        if (cur == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else m_run = 1;
        m_last = cur;
        if (m_full && strm.out_ready) m_full = 1'b0;
        if (m_run == SC + 1 && $countones(dig_sel) == 1) begin
            d = 0;
            for (int i = 0; i < ND; i++) if (dig_sel[i]) d = i;
            code = ref_decode(seg_n);
            if (code == -2) begin
                m_blank[d] = 1'b1;
            end else begin
                m_blank[d] = 1'b0;
                m_err[d]   = (code < 0);
                m_val[d]   = (code < 0) ? 0 : code;
                if (!m_full) begin
                    sb.push_back('{d, m_val[d], m_err[d]});
                    m_full = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic [6:0] s, input logic [ND-1:0] d, input bit r);
        seg_n = s;
        dig_sel = d;
        strm.out_ready = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // rmode 0/1: fixed ready, 2: random ready every cycle
    task automatic hold(input logic [6:0] s, input logic [ND-1:0] d, input int n, input int rmode);
        for (int k = 0; k < n; k++)
            step(s, d, (rmode == 2) ? bit'($urandom % 2) : bit'(rmode));
    endtask

    task automatic check_regs(input string tag);
        logic [4*ND-1:0] ev;
        logic [ND-1:0]   ee, eb;
        for (int i = 0; i < ND; i++) begin
            ev[4*i +: 4] = 4'(m_val[i]);
            ee[i] = m_err[i];
            eb[i] = m_blank[i];
        end
        check({tag, "_vals"}, 32'(digit_vals), 32'(ev));
        check({tag, "_errs"}, 32'(digit_errs), 32'(ee));
        check({tag, "_blank"}, 32'(digit_blank), 32'(eb));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(strm.out_valid), 32'd0);
        check({tag, "_payload"}, 32'({strm.out_digit, strm.out_nibble, strm.out_err}), 32'd0);
        check({tag, "_vals"}, 32'(digit_vals), 32'd0);
        check({tag, "_errs"}, 32'(digit_errs), 32'd0);
        check({tag, "_blank"}, 32'(digit_blank), 32'h3F);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks payload stability under stall
    bit          stall = 1'b0;
    logic [31:0] held_pl = '0;
    always @(negedge clk) begin
        beat_t b;
        if (!reset_n) begin
            stall = 1'b0;
        end else begin
            if (stall)
                check("stall_stable", 32'({strm.out_valid, strm.out_digit, strm.out_nibble, strm.out_err}), held_pl);
            if (strm.out_valid && strm.out_ready) begin
                n_beats++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got digit %0d nibble %0h err %0b expected no beat",
                             strm.out_digit, strm.out_nibble, strm.out_err);
                end else begin
                    b = sb.pop_front();
                    check("beat", 32'({strm.out_digit, strm.out_nibble, strm.out_err}),
                          32'({3'(b.digit), 4'(b.nib), b.err}));
                end
            end
            stall   = strm.out_valid && !strm.out_ready;
            held_pl = 32'({strm.out_valid, strm.out_digit, strm.out_nibble, strm.out_err});
        end
    end

    initial begin
        int n0;
        logic [ND-1:0] rs;
        logic [6:0]    rp;
        strm.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // T1: one pattern held long produces exactly one beat
        n0 = n_beats;
        hold(7'b0100100, 6'b000001, 20, 1);
        hold(7'h7F, 6'b000000, 3, 1);
        check("t1_count", 32'(n_beats - n0), 32'd1);
        check("t1_digit0", 32'(digit_vals[3:0]), 32'd2);
        check_regs("t1");

        // T2: every legal code on digit 5
        n0 = n_beats;
        for (int c = 0; c < 16; c++) hold(REF[c], 6'b100000, 6, 1);
        hold(7'h7F, 6'b000000, 3, 1);
        check("t2_count", 32'(n_beats - n0), 32'd16);
        check("t2_digit5", 32'(digit_vals[23:20]), 32'hF);
        check_regs("t2");

        // T3: illegal then blank on digit 2
        hold(7'b1010101, 6'b000100, 6, 1);
        hold(7'h7F, 6'b000000, 3, 1);
        check("t3_errs", 32'(digit_errs), 32'h04);
        n0 = n_beats;
        hold(7'h7F, 6'b000100, 6, 1);
        hold(7'h7F, 6'b000000, 3, 1);
        check("t3_blank_nobeat", 32'(n_beats - n0), 32'd0);
        check("t3_blank2", 32'({digit_blank[2], digit_errs[2]}), 32'b11);
        check_regs("t3");

        // T4: too-short holds and a multi-hot strobe
        n0 = n_beats;
        for (int k = 0; k < 10; k++) hold((k % 2) ? REF[3] : REF[8], 6'b000001, 3, 1);
        hold(REF[9], 6'b000011, 10, 1);
        hold(7'h7F, 6'b000000, 3, 1);
        check("t4_count", 32'(n_beats - n0), 32'd0);
        check_regs("t4");

        // T5: stalled stream, second result dropped
        n0 = n_beats;
        hold(REF[5], 6'b000010, 6, 0);
        hold(REF[7], 6'b001000, 6, 0);
        check("t5_ovf", 32'(overflow), 32'd1);
        check("t5_held", 32'({strm.out_valid, strm.out_digit}), 32'({1'b1, 3'd1}));
        check("t5_digit3", 32'(digit_vals[15:12]), 32'd7);
        hold(7'h7F, 6'b000000, 3, 1);
        check("t5_count", 32'(n_beats - n0), 32'd1);
        check_regs("t5");

        // Random traffic with random back-pressure
        for (int it = 0; it < 150; it++) begin
            case ($urandom % 8)
                0:       rs = '0;
                1:       rs = ND'(7 << ($urandom % 4));
                default: rs = ND'(1 << ($urandom % ND));
            endcase
            case ($urandom % 4)
                0:       rp = 7'h7F;
                1:       rp = 7'($urandom);
                default: rp = REF[$urandom % 16];
            endcase
            hold(rp, rs, 1 + int'($urandom % 7), 2);
        end
        hold(7'h7F, 6'b000000, 4, 1);
        check_regs("rand");

        // T6: reset with a pending beat and a partially filtered pattern
        hold(REF[1], 6'b000001, 6, 0);
        hold(REF[2], 6'b000100, 3, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        n0 = n_beats;
        hold(REF[2], 6'b000100, 3, 1);
        check("t6_no_early", 32'(n_beats - n0), 32'd0);
        hold(REF[2], 6'b000100, 5, 1);
        hold(7'h7F, 6'b000000, 3, 1);
        check("t6_count", 32'(n_beats - n0), 32'd1);
        check_regs("t6");
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
